// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants for the elastic pipeline register: occupancy-count width
// helper and the stall-counter width / saturation value.
package elastic_pipe_pkg;

    localparam int STALL_W = 32;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// Handshake bundle for elastic_pipe_reg: upstream val/rdy/msg and downstream
// val/rdy/msg. The slave modport is the register's view, master is the environment's.
interface elastic_pipe_reg_if #(
    parameter int p_nbits = 32
);
    logic               in_val;
    logic               in_rdy;
    logic [p_nbits-1:0] in_msg;
    logic               out_val;
    logic               out_rdy;
    logic [p_nbits-1:0] out_msg;

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg
    );

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg
    );
endinterface

// File: rtl/elastic_pipe_reg_stage.sv
// One elastic stage: a valid bit plus a data register, ready whenever empty or
// when the stage downstream is ready.
module elastic_pipe_stage #(
    parameter int                 p_nbits       = 32,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               up_val,
    input  logic [p_nbits-1:0] up_msg,
    input  logic               dn_rdy,
    output logic               val,
    output logic [p_nbits-1:0] msg,
    output logic               rdy
);
    logic               val_q, val_d;
    logic [p_nbits-1:0] msg_q, msg_d;

    assign rdy = !val_q || dn_rdy;
    assign val = val_q;
    assign msg = msg_q;

    // Data only loads on a valid upstream beat so a drained stage keeps its last message.
    always_comb begin
        val_d = val_q;
        msg_d = msg_q;
        if (flush) begin
            val_d = 1'b0;
        end else if (rdy) begin
            val_d = up_val;
            if (up_val) begin
                msg_d = up_msg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= 1'b0;
            msg_q <= p_reset_value;
        end else begin
            val_q <= val_d;
            msg_q <= msg_d;
        end
    end
endmodule

// File: rtl/elastic_pipe_reg.sv
// Multi-stage flushable elastic pipeline register with a combinational ready chain.
// Optional stall counter enabled by ELASTIC_PIPE_REG_PERF_EN.
module elastic_pipe_reg
    import elastic_pipe_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter int                 p_depth       = 2,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    elastic_pipe_reg_if.slave                bus,
    output logic [count_width(p_depth)-1:0]  count
`ifdef ELASTIC_PIPE_REG_PERF_EN
   ,output logic [STALL_W-1:0]               stall_cycles
`endif
);
    localparam int CW = count_width(p_depth);

    // Index 0 is the upstream port; index gi+1 is the output of stage gi.
    logic [p_depth:0]   val_w;
    logic [p_nbits-1:0] msg_w [p_depth+1];
    logic [p_depth:0]   rdy_w;
    logic               blocked;
    logic               out_val_w;

    assign val_w[0]       = bus.in_val;
    assign msg_w[0]       = bus.in_msg;
    assign rdy_w[p_depth] = bus.out_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < p_depth; gi++) begin : g_stage
            elastic_pipe_stage #(
                .p_nbits       (p_nbits),
                .p_reset_value (p_reset_value)
            ) u_stage (
                .clk    (clk),
                .reset  (reset),
                .flush  (flush),
                .up_val (val_w[gi]),
                .up_msg (msg_w[gi]),
                .dn_rdy (rdy_w[gi+1]),
                .val    (val_w[gi+1]),
                .msg    (msg_w[gi+1]),
                .rdy    (rdy_w[gi])
            );
        end
    endgenerate

    // Reset and flush both suppress transfers on either port in the same cycle.
    assign blocked     = reset || flush;
    assign out_val_w   = val_w[p_depth] && !blocked;
    assign bus.in_rdy  = rdy_w[0] && !blocked;
    assign bus.out_val = out_val_w;
    assign bus.out_msg = msg_w[p_depth];

    always_comb begin
        count = '0;
        for (int i = 1; i <= p_depth; i++) begin
            count = count + CW'(val_w[i]);
        end
    end

`ifdef ELASTIC_PIPE_REG_PERF_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_val_w && !bus.out_rdy && stall_q != STALL_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed scenarios plus random traffic, checked
// every cycle against a message/position queue model.
module tb_elastic_pipe_reg;
    import elastic_pipe_pkg::*;

    localparam int           D  = 3;
    localparam int           W  = 16;
    localparam logic [W-1:0] RV = 16'hDEAD;
    localparam int           CW = count_width(D);

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [CW-1:0] count;
`ifdef ELASTIC_PIPE_REG_PERF_EN
    logic [STALL_W-1:0] stall_cycles;
`endif

    elastic_pipe_reg_if #(.p_nbits(W)) bus ();

    elastic_pipe_reg #(
        .p_nbits       (W),
        .p_depth       (D),
        .p_reset_value (RV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus),
        .count        (count)
`ifdef ELASTIC_PIPE_REG_PERF_EN
       ,.stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Model: each in-flight message with its stage position (0 = input side).
    typedef struct {
        logic [W-1:0] msg;
        int           pos;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] last_data;
    longint       stall_m;
    int           vectors;
    int           miscompares;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock of stimulus, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic iv, input logic [W-1:0] im, input logic ordy,
                         input logic fl, input logic rs);
        ent_t nq[$];
        int   limit;
        logic blk, exp_oval, exp_irdy;

        bus.in_val  = iv;
        bus.in_msg  = im;
        bus.out_rdy = ordy;
        flush       = fl;
        reset       = rs;
        @(negedge clk);

        blk      = rs || fl;
        exp_oval = !blk && q.size() > 0 && q[0].pos == D - 1;
        limit    = D;
        for (int k = 0; k < q.size(); k++) begin
            ent_t e;
            e = q[k];
            if (k == 0 && e.pos == D - 1 && ordy) continue;
            e.pos = (e.pos + 1 < limit) ? e.pos + 1 : limit - 1;
            limit = e.pos;
            nq.push_back(e);
        end
        exp_irdy = !blk && limit > 0;

        check_val("in_rdy",  32'(bus.in_rdy),  32'(exp_irdy));
        check_val("out_val", 32'(bus.out_val), 32'(exp_oval));
        check_val("out_msg", 32'(bus.out_msg), 32'(last_data));
        check_val("count",   32'(count),       32'(q.size()));
`ifdef ELASTIC_PIPE_REG_PERF_EN
        check_val("stall",   stall_cycles,     32'(stall_m));
`endif
        if (iv && exp_irdy) $display("accept msg %0h", im);
        if (exp_oval && ordy) $display("emit   msg %0h", q[0].msg);

        if (rs) begin
            q.delete();
            last_data = RV;
            stall_m   = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (exp_oval && !ordy && stall_m < 64'hFFFF_FFFF) stall_m++;
            q = nq;
            foreach (q[k]) if (q[k].pos == D - 1) last_data = q[k].msg;
            if (iv && exp_irdy) q.push_back('{msg: im, pos: 0});
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.in_val  = 1'b0;
        bus.in_msg  = '0;
        bus.out_rdy = 1'b0;
        flush       = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        last_data = RV;
        stall_m   = 0;

        // Held reset, then the first free cycle must be ready and empty.
        cycle(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream with downstream always ready.
        cycle(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < D + 1; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Fill while stalled, then release with a simultaneous accept.
        cycle(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000D, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000D, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000D, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < D + 1; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // A lone message stalled at the tail must not block later stages.
        cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Full pipe flushed: nothing may emerge afterwards.
        cycle(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0008, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < D + 1; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Stall accounting: 7 stalled cycles with a message at the output.
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < D - 1; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef ELASTIC_PIPE_REG_PERF_EN
        check_val("stall7", stall_cycles, 32'd7);
`endif
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Mid-stream reset with flush also high: reset wins.
        cycle(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h5678, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h9ABC, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 16'h4321, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < D + 1; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom()),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
